// File: rtl/serial_pkg.sv
// Shared definitions for the serial blocks: the two-state shifter encoding,
// the default idle line level and the counter-width helper.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  // Bits needed to hold any value in 0..n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_hold_reg.sv
// One-entry holding register: captures a word while the shifter is busy and
// hands it over when the shifter frees up.
module serial_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full <= 1'b1;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload is not reset; it is only ever read while full=1, so a
  // reset on this wide register would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q <= wr_data;
    end
  end

  assign rd_data = data_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the sequence detector's w input.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every word.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT,
  parameter int   MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             w,
  output logic             bit_valid,
  output logic             word_start
);

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = count_width(WIDTH);

  state_t           state, state_next;
  logic [FLEN-1:0]  shreg, load_word, shifted;
  logic [CW-1:0]    cnt;
  logic             first;
  logic             busy, last, free, accept;
  logic             load, shift_en, hold_wr, hold_rd;
  logic             hold_full, out_bit;
  logic [WIDTH-1:0] hold_reg, src;

  assign busy     = (state == SHIFT);
  assign last     = busy && (cnt == CW'(FLEN - 1));
  assign free     = !busy || last;
  assign in_ready = !hold_full;
  assign accept   = in_valid && in_ready;

  // A held word always wins; accept cannot be high then since in_ready=0.
  assign src     = hold_full ? hold_reg : in_data;
  assign hold_wr = accept && !free;
  assign hold_rd = free && hold_full;

  serial_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hold_wr),
    .wr_data (in_data),
    .rd_en   (hold_rd),
    .rd_data (hold_reg),
    .full    (hold_full)
  );

  // The parity bit sits at the far end of shreg so it leaves after the data.
  always_comb begin
`ifdef BIT_SERIALIZER_PARITY_EN
    if (MSB_FIRST != 0) load_word = {src, ^src};
    else                load_word = {^src, src};
`else
    load_word = src;
`endif
    if (MSB_FIRST != 0) begin
      shifted = {shreg[FLEN-2:0], 1'b0};
      out_bit = shreg[FLEN-1];
    end else begin
      shifted = {1'b0, shreg[FLEN-1:1]};
      out_bit = shreg[0];
    end
  end

  // NOTE: every signal gets a default before the branches, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    if (free) begin
      if (hold_full || accept) begin
        load       = 1'b1;
        state_next = SHIFT;
      end else begin
        state_next = IDLE;
      end
    end else begin
      shift_en = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        shreg <= load_word;
        cnt   <= '0;
        first <= 1'b1;
      end else if (shift_en) begin
        shreg <= shifted;
        cnt   <= cnt + CW'(1);
        first <= 1'b0;
      end
    end
  end

  assign w          = busy ? out_bit : IDLE_BIT;
  assign bit_valid  = busy;
  assign word_start = busy && first;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: a WIDTH=4 MSB-first instance and a
// WIDTH=8 LSB-first instance; expected streams are hand-written constants.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FL4 = 5;
  localparam int FL8 = 9;
  localparam logic [FL4-1:0]   EXP_1001 = 5'b10010;
  localparam logic [2*FL4-1:0] EXP_B2B  = 10'b10100_01010;
  localparam logic [FL4-1:0]   EXP_0110 = 5'b01100;
  localparam logic [FL4-1:0]   EXP_1011 = 5'b10111;
  localparam logic [FL8-1:0]   EXP_LSB  = 9'b1_0000000_1;
`else
  localparam int FL4 = 4;
  localparam int FL8 = 8;
  localparam logic [FL4-1:0]   EXP_1001 = 4'b1001;
  localparam logic [2*FL4-1:0] EXP_B2B  = 8'b1010_0101;
  localparam logic [FL4-1:0]   EXP_0110 = 4'b0110;
  localparam logic [FL4-1:0]   EXP_1011 = 4'b1011;
  localparam logic [FL8-1:0]   EXP_LSB  = 8'b1_0000000;
`endif
  localparam logic IDLE = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data4;
  logic       in_valid4, in_ready4, w4, bit_valid4, word_start4;
  logic [7:0] in_data8;
  logic       in_valid8, in_ready8, w8, bit_valid8, word_start8;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .w(w4), .bit_valid(bit_valid4), .word_start(word_start4)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut8 (
    .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .w(w8), .bit_valid(bit_valid8), .word_start(word_start8)
  );

  task automatic test_reset;
    in_valid4 = 1'b1;
    in_data4  = 4'hF;
    in_valid8 = 1'b1;
    in_data8  = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if ({w4, bit_valid4, word_start4, in_ready4} !== {IDLE, 1'b0, 1'b0, 1'b1}) begin
        n_miss++;
        $display("FAIL reset_dut4: w/bv/ws/rdy=%b required %b",
                 {w4, bit_valid4, word_start4, in_ready4}, {IDLE, 3'b001});
      end
      n_vec++;
      if ({w8, bit_valid8, in_ready8} !== {IDLE, 1'b0, 1'b1}) begin
        n_miss++;
        $display("FAIL reset_dut8: w/bv/rdy=%b required %b",
                 {w8, bit_valid8, in_ready8}, {IDLE, 2'b01});
      end
    end
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if (bit_valid4 !== 1'b0 || bit_valid8 !== 1'b0) begin
        n_miss++;
        $display("FAIL reset_no_accept: bv4=%b bv8=%b required 0 0", bit_valid4, bit_valid8);
      end
    end
  endtask

  // Sends one word on dut4 and checks the stream; exp holds bits first-out at MSB.
  task automatic run_word4(input string name, input logic [3:0] data,
                           input logic [FL4-1:0] exp, input bit chk_z);
    logic [3:0] zsr;
    logic       z;
    zsr       = {4{IDLE}};
    in_data4  = data;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    for (int i = 0; i < FL4; i++) begin
      @(negedge clk);
      n_vec++;
      if ({w4, bit_valid4, word_start4} !== {exp[FL4-1-i], 1'b1, (i == 0)}) begin
        n_miss++;
        $display("FAIL %s bit%0d: w/bv/ws=%b required %b", name, i,
                 {w4, bit_valid4, word_start4}, {exp[FL4-1-i], 1'b1, (i == 0)});
      end
      zsr = {zsr[2:0], w4};
      z   = (zsr == 4'b1001);
      if (chk_z) begin
        n_vec++;
        if (z !== (i == 3)) begin
          n_miss++;
          $display("FAIL %s detector_z cycle%0d: got %b required %b", name, i, z, (i == 3));
        end
      end
    end
    @(negedge clk);
    n_vec++;
    if ({w4, bit_valid4, word_start4} !== {IDLE, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL %s after: w/bv/ws=%b required %b", name,
               {w4, bit_valid4, word_start4}, {IDLE, 2'b00});
    end
  endtask

  task automatic test_single_word;
    run_word4("single_1001", 4'b1001, EXP_1001, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic exp_rdy;
    in_data4  = 4'hA;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_data4 = 4'h5;
    for (int i = 0; i < 2 * FL4; i++) begin
      @(negedge clk);
      exp_rdy = !(i >= 1 && i < FL4);
      n_vec++;
      if ({w4, bit_valid4, word_start4, in_ready4} !==
          {EXP_B2B[2*FL4-1-i], 1'b1, (i == 0 || i == FL4), exp_rdy}) begin
        n_miss++;
        $display("FAIL b2b bit%0d: w/bv/ws/rdy=%b required %b", i,
                 {w4, bit_valid4, word_start4, in_ready4},
                 {EXP_B2B[2*FL4-1-i], 1'b1, (i == 0 || i == FL4), exp_rdy});
      end
      if (i == 0) begin
        @(posedge clk);
        #1 in_valid4 = 1'b0;
      end
    end
    @(negedge clk);
    n_vec++;
    if ({w4, bit_valid4, in_ready4} !== {IDLE, 1'b0, 1'b1}) begin
      n_miss++;
      $display("FAIL b2b after: w/bv/rdy=%b required %b", {w4, bit_valid4, in_ready4}, {IDLE, 2'b01});
    end
  endtask

  task automatic test_lsb_first;
    in_data8  = 8'h01;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    for (int i = 0; i < FL8; i++) begin
      @(negedge clk);
      n_vec++;
      if ({w8, bit_valid8, word_start8} !== {EXP_LSB[FL8-1-i], 1'b1, (i == 0)}) begin
        n_miss++;
        $display("FAIL lsb bit%0d: w/bv/ws=%b required %b", i,
                 {w8, bit_valid8, word_start8}, {EXP_LSB[FL8-1-i], 1'b1, (i == 0)});
      end
    end
    @(negedge clk);
    n_vec++;
    if ({w8, bit_valid8} !== {IDLE, 1'b0}) begin
      n_miss++;
      $display("FAIL lsb after: w/bv=%b required %b", {w8, bit_valid8}, {IDLE, 1'b0});
    end
  endtask

  task automatic test_reset_mid_word;
    in_data4  = 4'b1111;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_data4 = 4'b1100;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({w4, bit_valid4, in_ready4} !== 3'b110) begin
      n_miss++;
      $display("FAIL mid_before: w/bv/rdy=%b required 110", {w4, bit_valid4, in_ready4});
    end
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if ({w4, bit_valid4, word_start4, in_ready4} !== {IDLE, 1'b0, 1'b0, 1'b1}) begin
      n_miss++;
      $display("FAIL mid_async: w/bv/ws/rdy=%b required %b",
               {w4, bit_valid4, word_start4, in_ready4}, {IDLE, 3'b001});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (FL4 + 2) begin
      @(negedge clk);
      n_vec++;
      if ({w4, bit_valid4} !== {IDLE, 1'b0}) begin
        n_miss++;
        $display("FAIL mid_discard: w/bv=%b required %b", {w4, bit_valid4}, {IDLE, 1'b0});
      end
    end
    run_word4("mid_0110", 4'b0110, EXP_0110, 1'b0);
  endtask

  task automatic test_parity;
    run_word4("parity_1011", 4'b1011, EXP_1011, 1'b0);
  endtask

  initial begin
    rst       = 1'b0;
    in_data4  = '0;
    in_valid4 = 1'b0;
    in_data8  = '0;
    in_valid8 = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
